d_redu: RTL and testbench
=========================

# d_redu

- Pipelined modular reduction unit for the Dilithium prime q = 8380417 = 2^23 − 2^13 + 1.
- Reduces any 48-bit unsigned value, such as the product of two 23-bit residues, to its canonical residue in [0, q−1].
- Sits behind the NTT/pointwise multiplier datapath.
- Accepts one operand per clock, with a fixed latency.

## Interface
Parameters:
- None. q is a hard-wired constant 23'd8380417.

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in is sampled when high at a rising edge.
- data_in  input  48  unsigned operand; any value 0 … 2^48−1 is legal.
- out_valid  output  1  high for exactly one cycle per accepted operand.
- result  output  23  data_in mod q, always < q while out_valid is high.

## Operation
- Required function: result = data_in mod q, exactly, for every 48-bit input.
- Full-range correctness is required, not just inputs ≤ (q−1)^2.
- No divider and no generic `%` operator. Use the identity 2^23 ≡ 2^13 − 1 (mod q):
  - Fold stage A: split x = H·2^23 + L, with H 25 bits and L 23 bits. Form x1 = L + (H<<13) − H, carrying a sign/width-safe intermediate of at least 40 bits.
  - Fold stage B: apply the same fold to x1 until the value is < 4q, with an explicit correction constant to keep intermediates non-negative.
  - Final stage: conditional subtraction of q, 2q or 3q, selecting the smallest non-negative candidate.
- All intermediates are unsigned with explicit widths; no truncation may lose bits before the final result.
- No backpressure: one operand accepted per cycle; back-to-back valid inputs produce back-to-back valid outputs in order.
- result holds its last valid value while out_valid is low.

## Timing
- Latency L from the sampling edge to out_valid:
  - 3 cycles with D_REDU_OUT_REG_EN.
  - 2 cycles without it.
- Throughput: 1 result per cycle.
- Reset values: out_valid = 0, result = 0, all internal valid bits = 0.
- Reset mid-operation: all in-flight operands are discarded and no out_valid pulses arise from them.
- An operand presented in a cycle where rst is high is dropped.
- Reset deasserted: the first operand sampled on the next edge emerges L cycles later.
- An in_valid gap of N cycles produces an out_valid gap of N cycles.

## Configuration
- D_REDU_OUT_REG_EN, defined:
  - Extra register stage on result/out_valid after the final subtraction.
  - L = 3; outputs are driven directly from flops.
- D_REDU_OUT_REG_EN, undefined:
  - Final subtraction/select feeds the output registers of stage 2.
  - L = 2; function is identical.

## Test plan
- Boundaries, each with a single valid pulse:
  - 0 → 0.
  - 8380416 → 8380416.
  - 8380417 → 0.
  - 8380517 → 100.
  - 54321 → 54321.
- Multiples and maximum product:
  - 5·q → 0.
  - 123456·q → 0.
  - 70231372333056 ((q−1)^2) → 1.
  - 70231372333050 → 8380412.
- Full-width inputs:
  - 48'hFFFFFF → 16381.
  - 48'hFFFFFF000000 → 180198.
  - 48'hFFFFFFFFFFFF → 196579.
- Streaming: 10,000 random 48-bit inputs, one per cycle with random in_valid gaps.
  - Results must match a reference `%` model in order, with exactly L-cycle latency.
- Reset: assert rst with 2 operands in flight.
  - No out_valid for them; result = 0 and out_valid = 0 the cycle after reset.
  - Next operand returns correctly after L cycles.
- Build with and without D_REDU_OUT_REG_EN: the same vectors pass, with latency 3 and 2 respectively.

Source files
------------

// File: rtl/d_redu.sv
// Pipelined reduction of a 48-bit unsigned value modulo q = 2^23 - 2^13 + 1.
// Optional output register stage enabled by D_REDU_OUT_REG_EN (latency 3, else 2).
module d_redu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [47:0] data_in,
    output logic        out_valid,
    output logic [22:0] result
);

    localparam int unsigned RW  = 23;
    localparam int unsigned X1W = 40;
    localparam int unsigned X2W = 31;
    localparam int unsigned X3W = 26;
    localparam int unsigned DW  = X3W + 1;

    localparam logic [DW-1:0] Q1 = DW'(8380417);
    localparam logic [DW-1:0] Q2 = DW'(2 * 8380417);
    localparam logic [DW-1:0] Q3 = DW'(3 * 8380417);

    // Stage A: fold the 25 high bits using 2^23 == 2^13 - 1 (mod q).
    // H<<13 >= H always, so every fold stays non-negative without an offset.
    logic [24:0]     h_a;
    logic [RW-1:0]   l_a;
    logic [X1W-1:0]  x1_d, x1_q;
    logic            v1_d, v1_q;

    always_comb begin
        h_a  = data_in[47:23];
        l_a  = data_in[22:0];
        x1_d = X1W'(l_a) + (X1W'(h_a) << 13) - X1W'(h_a);
        v1_d = in_valid;
    end

    // Stage B: two more folds bring x1 (< 2^39) below 2^23 + 2^21 < 4q.
    logic [16:0]     h_b1;
    logic [X2W-1:0]  x2_c;
    logic [7:0]      h_b2;
    logic [X3W-1:0]  x3_d, x3_q;
    logic            v2_d, v2_q;

    always_comb begin
        h_b1 = x1_q[39:23];
        x2_c = X2W'(x1_q[22:0]) + (X2W'(h_b1) << 13) - X2W'(h_b1);
        h_b2 = x2_c[30:23];
        x3_d = X3W'(x2_c[22:0]) + (X3W'(h_b2) << 13) - X3W'(h_b2);
        v2_d = v1_q;
    end

    // Final stage: pick the smallest non-negative of x, x-q, x-2q, x-3q.
    logic [DW-1:0] d0_c, d1_c, d2_c, d3_c;
    logic [RW-1:0] red_c;

    always_comb begin
        d0_c  = DW'(x3_q);
        d1_c  = d0_c - Q1;
        d2_c  = d0_c - Q2;
        d3_c  = d0_c - Q3;
        red_c = d0_c[RW-1:0];
        if (!d3_c[DW-1]) begin
            red_c = d3_c[RW-1:0];
        end else if (!d2_c[DW-1]) begin
            red_c = d2_c[RW-1:0];
        end else if (!d1_c[DW-1]) begin
            red_c = d1_c[RW-1:0];
        end
    end

    logic [RW-1:0] result_d, result_q;
    logic          out_valid_d, out_valid_q;

`ifdef D_REDU_OUT_REG_EN
    logic [RW-1:0] fin_d, fin_q;
    logic          fin_v_d, fin_v_q;

    always_comb begin
        fin_d       = fin_q;
        fin_v_d     = v2_q;
        if (v2_q) begin
            fin_d = red_c;
        end
        result_d    = result_q;
        out_valid_d = fin_v_q;
        if (fin_v_q) begin
            result_d = fin_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fin_q   <= '0;
            fin_v_q <= 1'b0;
        end else begin
            fin_q   <= fin_d;
            fin_v_q <= fin_v_d;
        end
    end
`else
    always_comb begin
        result_d    = result_q;
        out_valid_d = v2_q;
        if (v2_q) begin
            result_d = red_c;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q        <= '0;
            v1_q        <= 1'b0;
            x3_q        <= '0;
            v2_q        <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x1_q        <= x1_d;
            v1_q        <= v1_d;
            x3_q        <= x3_d;
            v2_q        <= v2_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_d_redu.sv
// Scoreboard bench for d_redu: directed boundaries, random stream, reset flush.
module tb_d_redu;

`ifdef D_REDU_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam longint unsigned Q = 64'd8380417;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [47:0] data_in;
    logic        out_valid;
    logic [22:0] result;

    d_redu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
        .result    (result)
    );

    typedef struct {
        logic [22:0] exp;
        int          cyc;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [22:0] last_res = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one operand on the falling edge; it is sampled on the next rising edge.
    task automatic drive_one(input logic [47:0] x, input logic [22:0] exp, input bit push);
        sb_entry_t e;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = x;
        if (push) begin
            e.exp = exp;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Monitor: sample just after each rising edge.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_result", 64'(result), 64'd0);
                last_res = '0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'(result), 64'(e.exp));
                    check("latency", 64'(cyc - e.cyc), 64'(LAT));
                end
                last_res = result;
            end else begin
                check("hold", 64'(result), 64'(last_res));
            end
        end
    end

    longint unsigned dir_in  [12];
    longint unsigned dir_exp [12];

    initial begin
        longint unsigned x;
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;

        dir_in[0]  = 64'd0;               dir_exp[0]  = 64'd0;
        dir_in[1]  = 64'd8380416;         dir_exp[1]  = 64'd8380416;
        dir_in[2]  = 64'd8380417;         dir_exp[2]  = 64'd0;
        dir_in[3]  = 64'd8380517;         dir_exp[3]  = 64'd100;
        dir_in[4]  = 64'd54321;           dir_exp[4]  = 64'd54321;
        dir_in[5]  = 5 * Q;               dir_exp[5]  = 64'd0;
        dir_in[6]  = 123456 * Q;          dir_exp[6]  = 64'd0;
        dir_in[7]  = 64'd70231372333056;  dir_exp[7]  = 64'd1;
        dir_in[8]  = 64'd70231372333050;  dir_exp[8]  = 64'd8380412;
        dir_in[9]  = 64'hFFFFFF;          dir_exp[9]  = 64'd16381;
        dir_in[10] = 64'hFFFFFF000000;    dir_exp[10] = 64'd180198;
        dir_in[11] = 64'hFFFFFFFFFFFF;    dir_exp[11] = 64'd196579;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Directed boundaries, one isolated valid pulse each.
        for (int i = 0; i < 12; i++) begin
            drive_one(48'(dir_in[i]), 23'(dir_exp[i]), 1'b1);
            idle(LAT + 1);
        end

        // Random stream with random gaps, checked against a % reference.
        for (int i = 0; i < 10000; i++) begin
            x = {32'($urandom), 32'($urandom)};
            x = x & 64'hFFFF_FFFF_FFFF;
            drive_one(48'(x), 23'(x % Q), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 3));
            end
        end
        idle(LAT + 2);

        // Reset with two operands in flight; they must never appear.
        drive_one(48'd123456789, '0, 1'b0);
        drive_one(48'hABCDEF012345, '0, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        data_in  = 48'd999999999;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        x = 64'h7FFF_0000_1234;
        drive_one(48'(x), 23'(x % Q), 1'b1);
        drive_one(48'd8380416, 23'd8380416, 1'b1);
        idle(1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        check("drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
